// File: rtl/udp_tx_arb.sv
// udp_tx_arb: round-robin arbiter and sequencer that shares one UDP transmit engine between two packet sources
module udp_tx_arb #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_req,
  input  logic [15:0] ch0_byte_num,
  input  logic [47:0] ch0_des_mac,
  input  logic [31:0] ch0_des_ip,
  output logic        ch0_ack,
  output logic        ch0_data_req,
  input  logic [7:0]  ch0_data,
  output logic        ch0_done,
  output logic        ch0_err,
  input  logic        ch1_req,
  input  logic [15:0] ch1_byte_num,
  input  logic [47:0] ch1_des_mac,
  input  logic [31:0] ch1_des_ip,
  output logic        ch1_ack,
  output logic        ch1_data_req,
  input  logic [7:0]  ch1_data,
  output logic        ch1_done,
  output logic        ch1_err,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  output logic [7:0]  tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;
  localparam logic [7:0]  GAP_LD = 8'(GAP_CYCLES);
  localparam logic [15:0] WD_MAX = 16'(TIMEOUT_CYCLES);
  state_t state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d, win;
  logic [15:0] byte_num_q, byte_num_d, wd_q, wd_d;
  logic [47:0] des_mac_q, des_mac_d;
  logic [31:0] des_ip_q, des_ip_d;
  logic [7:0] gap_q, gap_d;
  logic [1:0] ack_q, ack_d, done_q, done_d, err_q, err_d, req;
  assign req = {ch1_req, ch0_req};
  // on a tie the channel not served last wins
  assign win = &req ? ~last_q : req[1];
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    byte_num_d = byte_num_q;
    des_mac_d  = des_mac_q;
    des_ip_d   = des_ip_q;
    wd_d       = wd_q;
    gap_d      = gap_q;
    ack_d      = '0;
    done_d     = '0;
    err_d      = '0;
    case (state_q)
      IDLE: if (|req) begin
        state_d    = START;
        gnt_d      = win;
        last_d     = win;
        byte_num_d = win ? ch1_byte_num : ch0_byte_num;
        des_mac_d  = win ? ch1_des_mac : ch0_des_mac;
        des_ip_d   = win ? ch1_des_ip : ch0_des_ip;
        ack_d[win] = 1'b1;
      end
      START: begin
        wd_d           = '0;
        state_d        = byte_num_q == '0 ? IDLE : BUSY;
        done_d[gnt_q]  = byte_num_q == '0;
        err_d[gnt_q]   = byte_num_q == '0;
      end
      BUSY: begin
        wd_d = wd_q + 16'd1;
        if (tx_done || wd_d == WD_MAX) begin
          state_d       = GAP;
          gap_d         = GAP_LD;
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = !tx_done;
        end
      end
      default: begin
        gap_d   = gap_q - 8'd1;
        state_d = gap_d == '0 ? IDLE : GAP;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      byte_num_q <= '0;
      des_mac_q  <= '0;
      des_ip_q   <= '0;
      wd_q       <= '0;
      gap_q      <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      byte_num_q <= byte_num_d;
      des_mac_q  <= des_mac_d;
      des_ip_q   <= des_ip_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
  assign busy         = state_q != IDLE;
  assign tx_start_en  = state_q == START && byte_num_q != '0;
  assign tx_byte_num  = byte_num_q;
  assign des_mac      = des_mac_q;
  assign des_ip       = des_ip_q;
  assign tx_data      = state_q == IDLE ? 8'd0 : gnt_q ? ch1_data : ch0_data;
  assign ch0_data_req = state_q == BUSY && tx_req && !gnt_q;
  assign ch1_data_req = state_q == BUSY && tx_req && gnt_q;
  assign ch0_ack      = ack_q[0];
  assign ch1_ack      = ack_q[1];
  assign ch0_done     = done_q[0];
  assign ch1_done     = done_q[1];
  assign ch0_err      = err_q[0];
  assign ch1_err      = err_q[1];
endmodule

// File: tb/tb_udp_tx_arb.sv
// tb_udp_tx_arb: directed scenarios with an expected-event scoreboard checked by a negedge monitor
module tb_udp_tx_arb;
  localparam int G = 5;
  localparam int T = 100;
  logic clk = 0, rst = 1;
  logic ch0_req = 0, ch1_req = 0;
  logic [15:0] ch0_byte_num = 0, ch1_byte_num = 0;
  logic [47:0] ch0_des_mac = 0, ch1_des_mac = 0;
  logic [31:0] ch0_des_ip = 0, ch1_des_ip = 0;
  logic [7:0] ch0_data = 8'h3c, ch1_data = 8'hc3;
  logic ch0_ack, ch0_data_req, ch0_done, ch0_err;
  logic ch1_ack, ch1_data_req, ch1_done, ch1_err;
  logic tx_start_en, busy;
  logic [15:0] tx_byte_num;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic [7:0] tx_data;
  logic tx_req = 0, tx_done = 0, engine_hang = 0;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int kind; int ch; int at; logic err; logic start; logic [15:0] n; logic [47:0] mac; logic [31:0] ip;} ev_t;
  ev_t sb[$];

  udp_tx_arb #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .ch0_req(ch0_req), .ch0_byte_num(ch0_byte_num), .ch0_des_mac(ch0_des_mac), .ch0_des_ip(ch0_des_ip),
    .ch0_ack(ch0_ack), .ch0_data_req(ch0_data_req), .ch0_data(ch0_data), .ch0_done(ch0_done), .ch0_err(ch0_err),
    .ch1_req(ch1_req), .ch1_byte_num(ch1_byte_num), .ch1_des_mac(ch1_des_mac), .ch1_des_ip(ch1_des_ip),
    .ch1_ack(ch1_ack), .ch1_data_req(ch1_data_req), .ch1_data(ch1_data), .ch1_done(ch1_done), .ch1_err(ch1_err),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .des_mac(des_mac), .des_ip(des_ip),
    .tx_data(tx_data), .tx_req(tx_req), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic go(int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_ack(int ch, int at, logic start, logic [15:0] n, logic [47:0] mac, logic [31:0] ip);
    ev_t e;
    e.kind = 0; e.ch = ch; e.at = at; e.err = 0; e.start = start; e.n = n; e.mac = mac; e.ip = ip;
    sb.push_back(e);
  endtask

  task automatic exp_done(int ch, int at, logic err, int nb);
    ev_t e;
    e.kind = 1; e.ch = ch; e.at = at; e.err = err; e.start = 0; e.n = 16'(nb); e.mac = 0; e.ip = 0;
    sb.push_back(e);
  endtask

  task automatic req_ch(int ch, logic [15:0] n, logic [47:0] mac, logic [31:0] ip);
    if (ch == 0) begin
      ch0_req = 1; ch0_byte_num = n; ch0_des_mac = mac; ch0_des_ip = ip;
    end else begin
      ch1_req = 1; ch1_byte_num = n; ch1_des_mac = mac; ch1_des_ip = ip;
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, tx_start_en, 0);
    chk({tag, "_len"}, tx_byte_num, 0);
    chk({tag, "_mac"}, des_mac, 0);
    chk({tag, "_ip"}, des_ip, 0);
    chk({tag, "_txdata"}, tx_data, 0);
    chk({tag, "_pulses"}, {ch1_ack, ch0_ack, ch1_done, ch0_done, ch1_err, ch0_err, ch1_data_req, ch0_data_req}, 0);
  endtask

  // payload sources: patterns chosen so the two channels never carry the same byte
  initial forever begin
    @(posedge clk);
    #1;
    ch0_data = 8'(cyc * 7 + 3);
    ch1_data = 8'(cyc * 13 + 90);
  end

  // engine model: byte requests for tx_byte_num cycles after the start pulse, then tx_done
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (tx_start_en && !rst) begin
        n = int'(tx_byte_num);
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          #1 tx_req = 1;
        end
        @(posedge clk);
        #1;
        tx_req = 0;
        tx_done = !engine_hang;
        @(posedge clk);
        #1 tx_done = 0;
      end
    end
  end

  // monitor: pops the scoreboard on every ack/done and checks the byte path while a grant is live
  initial begin
    ev_t e;
    int nb;
    logic act, g, a, d, er;
    nb = 0; act = 0; g = 0;
    forever begin
      @(negedge clk);
      if (ch0_data_req || ch1_data_req) begin
        chk("dreq_route", {ch1_data_req, ch0_data_req}, (act && tx_req) ? (g ? 2 : 1) : 0);
        chk("tx_data", tx_data, g ? ch1_data : ch0_data);
        nb++;
      end
      if (tx_start_en) chk("start_with_ack", ch0_ack | ch1_ack, 1);
      for (int c = 0; c < 2; c++) begin
        a  = c == 1 ? ch1_ack : ch0_ack;
        d  = c == 1 ? ch1_done : ch0_done;
        er = c == 1 ? ch1_err : ch0_err;
        if (er) chk("err_with_done", d, 1);
        if (a) begin
          if (sb.size() == 0) chk("ack_expected", a, 0);
          else begin
            e = sb.pop_front();
            chk("ack_slot", c, e.kind * 2 + e.ch);
            chk("ack_cycle", cyc, e.at);
            chk("ack_start_en", tx_start_en, e.start);
            chk("ack_byte_num", tx_byte_num, e.n);
            chk("ack_des_mac", des_mac, e.mac);
            chk("ack_des_ip", des_ip, e.ip);
            act = 1; g = c == 1; nb = 0;
          end
        end
        if (d) begin
          if (sb.size() == 0) chk("done_expected", d, 0);
          else begin
            e = sb.pop_front();
            chk("done_slot", 2 + c, e.kind * 2 + e.ch);
            chk("done_cycle", cyc, e.at);
            chk("done_err", er, e.err);
            chk("done_bytes", nb, e.n);
            act = 0;
          end
        end
      end
      if (rst) act = 0;
    end
  end

  initial begin
    int c;
    go(2);
    chk_reset("por");
    rst = 0;
    go(5);
    // simultaneous requests, twice: ch0 then ch1 each round
    for (int r = 0; r < 2; r++) begin
      c = cyc;
      req_ch(0, 8, 48'h0000_1111_2222, 32'h0a00_0001);
      req_ch(1, 6, 48'h0000_3333_4444, 32'h0a00_0002);
      exp_ack(0, c + 1, 1, 8, 48'h0000_1111_2222, 32'h0a00_0001);
      exp_done(0, c + 11, 0, 8);
      exp_ack(1, c + 17, 1, 6, 48'h0000_3333_4444, 32'h0a00_0002);
      exp_done(1, c + 25, 0, 6);
      go(c + 2);
      ch0_req = 0;
      go(c + 18);
      ch1_req = 0;
      go(c + 32);
    end
    // fairness: both held, grants alternate 0,1,0,1
    c = cyc;
    req_ch(0, 4, 48'h0200_0000_0010, 32'hc0a8_0110);
    req_ch(1, 3, 48'h0200_0000_0011, 32'hc0a8_0111);
    exp_ack(0, c + 1, 1, 4, 48'h0200_0000_0010, 32'hc0a8_0110);
    exp_done(0, c + 7, 0, 4);
    exp_ack(1, c + 13, 1, 3, 48'h0200_0000_0011, 32'hc0a8_0111);
    exp_done(1, c + 18, 0, 3);
    exp_ack(0, c + 24, 1, 4, 48'h0200_0000_0010, 32'hc0a8_0110);
    exp_done(0, c + 30, 0, 4);
    exp_ack(1, c + 36, 1, 3, 48'h0200_0000_0011, 32'hc0a8_0111);
    exp_done(1, c + 41, 0, 3);
    go(c + 25);
    ch0_req = 0;
    go(c + 37);
    ch1_req = 0;
    go(c + 48);
    // single 64-byte packet to broadcast MAC, 192.168.1.102
    c = cyc;
    req_ch(0, 64, 48'hffff_ffff_ffff, 32'hc0a8_0166);
    exp_ack(0, c + 1, 1, 64, 48'hffff_ffff_ffff, 32'hc0a8_0166);
    exp_done(0, c + 67, 0, 64);
    go(c + 2);
    ch0_req = 0;
    ch0_byte_num = 16'h1234;
    go(c + 70);
    chk("latched_len_after_done", tx_byte_num, 64);
    chk("latched_ip_after_done", des_ip, 32'hc0a8_0166);
    go(c + 75);
    // zero length on ch0, ch1 granted right after with no gap
    c = cyc;
    req_ch(0, 0, 48'h0200_0000_0005, 32'h0a00_0005);
    exp_ack(0, c + 1, 0, 0, 48'h0200_0000_0005, 32'h0a00_0005);
    exp_done(0, c + 2, 1, 0);
    go(c + 1);
    req_ch(1, 5, 48'h0200_0000_0006, 32'h0a00_0006);
    exp_ack(1, c + 3, 1, 5, 48'h0200_0000_0006, 32'h0a00_0006);
    exp_done(1, c + 10, 0, 5);
    go(c + 2);
    ch0_req = 0;
    go(c + 4);
    ch1_req = 0;
    go(c + 17);
    // watchdog: engine never reports done
    engine_hang = 1;
    c = cyc;
    req_ch(1, 8, 48'h0200_0000_0007, 32'h0a00_0007);
    exp_ack(1, c + 1, 1, 8, 48'h0200_0000_0007, 32'h0a00_0007);
    exp_done(1, c + 102, 1, 8);
    go(c + 2);
    ch1_req = 0;
    go(c + 106);
    chk("gap_after_timeout_busy", busy, 1);
    go(c + 107);
    chk("idle_after_timeout_gap", busy, 0);
    engine_hang = 0;
    go(c + 110);
    // reset in the middle of a packet, then a tie goes to ch0
    c = cyc;
    req_ch(0, 32, 48'h0200_0000_0008, 32'h0a00_0008);
    exp_ack(0, c + 1, 1, 32, 48'h0200_0000_0008, 32'h0a00_0008);
    go(c + 2);
    ch0_req = 0;
    go(c + 10);
    rst = 1;
    go(c + 11);
    rst = 0;
    chk_reset("mid_busy_rst");
    go(c + 15);
    chk("no_fwd_outside_busy", {ch1_data_req, ch0_data_req, tx_req}, 3'b001);
    go(c + 36);
    chk("stray_done_ignored", busy, 0);
    go(c + 40);
    req_ch(0, 2, 48'h0200_0000_0009, 32'h0a00_0009);
    req_ch(1, 2, 48'h0200_0000_000a, 32'h0a00_000a);
    exp_ack(0, c + 41, 1, 2, 48'h0200_0000_0009, 32'h0a00_0009);
    exp_done(0, c + 45, 0, 2);
    exp_ack(1, c + 51, 1, 2, 48'h0200_0000_000a, 32'h0a00_000a);
    exp_done(1, c + 55, 0, 2);
    go(c + 42);
    ch0_req = 0;
    go(c + 52);
    ch1_req = 0;
    go(c + 64);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/udp_tx_arb.md
# udp_tx_arb

Two-requester arbiter and sequencer for the board's UDP transmit engine. It sits between two packet sources and the single `udp` transmit port. The sources are channel 0, the control/response path, and channel 1, the bulk FFT/audio stream. The block grants the engine round-robin and latches the winner's length and destination. It issues the start pulse, routes the byte-request/data handshake to the granted source, and reports completion. It then enforces an inter-packet idle gap. A watchdog recovers the engine slot if `tx_done` never arrives.

## Interface
Parameters:
- `GAP_CYCLES`, 16: idle cycles between engine `tx_done` and the next grant; range 1..255.
- `TIMEOUT_CYCLES`, 20000: maximum cycles in BUSY before the packet is aborted; 16-bit.

Ports:
- `clk` in 1: `gmii_tx_clk` domain. One clock, synchronous active-high reset.
- `rst` in 1: synchronous reset, active high.
- `chN_req` in 1 (N=0,1): level request; held until `chN_ack`.
- `chN_byte_num` in 16: payload length in bytes; valid while `chN_req`.
- `chN_des_mac` in 48: destination MAC; valid while `chN_req`.
- `chN_des_ip` in 32: destination IP; valid while `chN_req`.
- `chN_ack` out 1: one-cycle pulse; request accepted and parameters latched.
- `chN_data_req` out 1: byte request forwarded from the engine to the granted channel.
- `chN_data` in 8: payload byte from the channel.
- `chN_done` out 1: one-cycle pulse at the end of the packet (success or error).
- `chN_err` out 1: one-cycle pulse coincident with `chN_done` on timeout or zero length.
- `tx_start_en` out 1: engine start pulse.
- `tx_byte_num` out 16: latched length to the engine.
- `des_mac` out 48: latched destination MAC to the engine.
- `des_ip` out 32: latched destination IP to the engine.
- `tx_data` out 8: muxed payload byte to the engine.
- `tx_req` in 1: engine byte request.
- `tx_done` in 1: engine packet-complete pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, START, BUSY, GAP.
- IDLE → START when any `chN_req` is high.
  - Winner: the sole requester. If both request, the channel not granted last wins.
  - The `last` pointer resets to 1, so channel 0 wins the first tie.
  - On the transition: register `gnt`, latch the winner's `byte_num`/`des_mac`/`des_ip` into the engine-side outputs, update `last`, and pulse `chN_ack`.
- Zero-length grant (`byte_num==0`): START does not assert `tx_start_en`. It pulses `chN_done` and `chN_err` together and returns to IDLE with no gap.
- START: `tx_start_en` = 1 for exactly one cycle, then BUSY. The watchdog counter clears.
- BUSY:
  - `chgnt_data_req = tx_req` (combinational); the other channel's `data_req` = 0.
  - `tx_data = chgnt_data` (combinational mux); 0 when no grant is active.
  - The engine's request-to-data latency passes through unchanged.
  - On `tx_done`: next cycle pulse `chgnt_done`, load the gap counter with `GAP_CYCLES`, go to GAP.
  - On watchdog count reaching `TIMEOUT_CYCLES` with no `tx_done`: pulse `chgnt_done` and `chgnt_err`, go to GAP.
- GAP: counter decrements each cycle. At 0 → IDLE. Requests are ignored during GAP.
- Latched engine-side parameters stay stable from grant until the next grant. They do not clear at done.
- `tx_done` outside BUSY is ignored. `tx_req` outside BUSY is not forwarded.
- A request that is still high after its own `done` is re-arbitrated normally. If the other channel is also requesting, the other channel wins.

## Timing
- Reset values: all pulses and `chN_data_req` = 0, `busy` = 0, `tx_data` = 0, latched length/MAC/IP = 0, state IDLE, `last` = 1, counters 0.
- Reset asserted mid-packet aborts immediately to the reset values. No `done` is issued.
- Cycle sequence:
  - Cycle t: `req` is seen in IDLE.
  - t+1: `chN_ack` = 1, state START, `tx_start_en` = 1, latched parameters valid.
  - t+2: BUSY.
- Request-to-start latency is 1 cycle.
- `tx_done` at cycle d gives `chN_done` at d+1.
- Next `chN_ack` is no earlier than d+1+`GAP_CYCLES`+1.
- Watchdog: abort fires on the cycle the counter reaches `TIMEOUT_CYCLES` (counted from the first BUSY cycle).
- `chN_data_req` → `tx_data` path is purely combinational and adds 0 cycles.

## Test plan
- **Single request:** ch0 requests 64 bytes, MAC 0xffffffffffff, IP 192.168.1.102; engine model drives `tx_req` 64 cycles, then `tx_done`. Required: `ch0_ack` and `tx_start_en` at t+1; `tx_byte_num` = 64; 64 `ch0_data_req` pulses mirrored onto `tx_data`; `ch0_done` 1 cycle after `tx_done`; `ch0_err` = 0.
- **Simultaneous requests, twice:** both channels request together. Required: first grant to ch0, second to ch1; second `ack` exactly `GAP_CYCLES`+2 cycles after the first `tx_done`; `ch0_data_req` never high while ch1 is granted.
- **Fairness:** ch1 requests continuously while ch0 re-requests after each of its packets. Required: grants alternate 0,1,0,1.
- **Timeout:** `TIMEOUT_CYCLES` = 100, engine never asserts `tx_done`. Required: `ch1_done` and `ch1_err` 100 cycles after entering BUSY, then GAP, then IDLE.
- **Zero length:** ch0 requests with `byte_num` = 0. Required: `ack`, no `tx_start_en`, `done` + `err` one cycle later; the next request is granted with no gap.
- **Reset mid-BUSY:** `rst` pulsed during BUSY. Required: all outputs return to reset values the next cycle, no `done` is issued, and the first tie afterwards goes to ch0.
